// File: rtl/fwd_pkg.sv
// fwd_pkg: opcodes, select encoding and tracker entry type shared by the forwarding unit and ID decode
package fwd_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int SEL_REGFILE = 0;
  localparam int TRK_AW = 5;
  typedef struct packed {
    logic              valid;
    logic [TRK_AW-1:0] rd;
    logic              is_load;
  } trk_entry_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-side request and EX-side bypass/stall/stat signals of the forwarding unit
interface fwd_hazard_unit_if #(parameter int FWD_DEPTH = 3, parameter int AW = 5);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [AW-1:0]    id_rd, id_rs1, id_rs2;
  logic             hold, flush;
  logic [SEL_W-1:0] rs1_sel, rs2_sel;
  logic             load_use_stall;
  logic [31:0]      stat_stalls, stat_fwds;
  modport master(output id_valid, id_opcode, id_rd, id_rs1, id_rs2, hold, flush,
                 input rs1_sel, rs2_sel, load_use_stall, stat_stalls, stat_fwds);
  modport slave(input id_valid, id_opcode, id_rd, id_rs1, id_rs2, hold, flush,
                output rs1_sel, rs2_sel, load_use_stall, stat_stalls, stat_fwds);
endinterface

// File: rtl/fwd_opdecode.sv
// fwd_opdecode: RV32I opcode to operand-use / writeback / load flags
module fwd_opdecode import fwd_pkg::*; (
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);
  assign uses_rs1  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2  = opcode inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  assign writes_rd = !(opcode inside {OP_STORE, OP_BRANCH});
  assign is_load   = opcode == OP_LOAD;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: producer tracker, registered EX bypass selects and load-use stall.
// Saturating statistics counters are built only when FWD_STATS_EN is defined.
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int FWD_DEPTH = 3,
  parameter int AW = 5
) (
  input logic clk,
  input logic reset_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  logic uses_rs1, uses_rs2, writes_rd, is_load;
  logic stall, kill;
  logic [SEL_W-1:0] hit1, hit2, rs1_sel_d, rs1_sel_q, rs2_sel_d, rs2_sel_q;
  trk_entry_t trk_d [FWD_DEPTH];
  trk_entry_t trk_q [FWD_DEPTH];
  fwd_opdecode u_dec (
    .opcode(bus.id_opcode), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .writes_rd(writes_rd), .is_load(is_load)
  );
  // Scan oldest to youngest so the youngest matching producer is left in hit.
  always_comb begin
    hit1 = SEL_W'(SEL_REGFILE);
    hit2 = SEL_W'(SEL_REGFILE);
    for (int k = FWD_DEPTH - 2; k >= 0; k--) begin
      if (uses_rs1 && bus.id_rs1 != AW'(0) && trk_q[k].valid && trk_q[k].rd == TRK_AW'(bus.id_rs1))
        hit1 = SEL_W'(k + 1);
      if (uses_rs2 && bus.id_rs2 != AW'(0) && trk_q[k].valid && trk_q[k].rd == TRK_AW'(bus.id_rs2))
        hit2 = SEL_W'(k + 1);
    end
  end
  assign stall = bus.id_valid && !bus.flush && trk_q[0].is_load && (hit1 == SEL_W'(1) || hit2 == SEL_W'(1));
  assign kill  = stall || bus.flush;
  always_comb begin
    trk_d     = trk_q;
    rs1_sel_d = rs1_sel_q;
    rs2_sel_d = rs2_sel_q;
    if (!bus.hold) begin
      for (int k = 1; k < FWD_DEPTH; k++) trk_d[k] = trk_q[k-1];
      trk_d[0].valid   = bus.id_valid && writes_rd && bus.id_rd != AW'(0) && !kill;
      trk_d[0].rd      = TRK_AW'(bus.id_rd);
      trk_d[0].is_load = is_load;
      rs1_sel_d = kill ? SEL_W'(SEL_REGFILE) : hit1;
      rs2_sel_d = kill ? SEL_W'(SEL_REGFILE) : hit2;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < FWD_DEPTH; k++) trk_q[k] <= '0;
      rs1_sel_q <= SEL_W'(SEL_REGFILE);
      rs2_sel_q <= SEL_W'(SEL_REGFILE);
    end else begin
      trk_q     <= trk_d;
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
    end
  end
  assign bus.rs1_sel        = rs1_sel_q;
  assign bus.rs2_sel        = rs2_sel_q;
  assign bus.load_use_stall = stall;
`ifdef FWD_STATS_EN
  logic [31:0] stalls_d, stalls_q, fwds_d, fwds_q;
  always_comb begin
    stalls_d = (!bus.hold && stall && stalls_q != '1) ? stalls_q + 32'd1 : stalls_q;
    fwds_d   = (!bus.hold && (rs1_sel_d != '0 || rs2_sel_d != '0) && fwds_q != '1) ? fwds_q + 32'd1 : fwds_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalls_q <= '0;
      fwds_q   <= '0;
    end else begin
      stalls_q <= stalls_d;
      fwds_q   <= fwds_d;
    end
  end
  assign bus.stat_stalls = stalls_q;
  assign bus.stat_fwds   = fwds_q;
`else
  assign bus.stat_stalls = '0;
  assign bus.stat_fwds   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: random instruction stream against a queue-based producer model, scoreboard-checked
module tb_fwd_hazard_unit;
  import fwd_pkg::*;
  localparam int D = 3;
  localparam int AW = 5;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef struct {
    int     stall;
    int     s1;
    int     s2;
    longint st;
    longint fw;
  } exp_t;
  typedef struct {
    int rd;
    bit ld;
  } prod_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.FWD_DEPTH(D), .AW(AW)) bus ();
  fwd_hazard_unit #(.FWD_DEPTH(D), .AW(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  exp_t   sb[$];
  prod_t  pipe[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     m_s1, m_s2;
  longint m_st, m_fw;
  task automatic check(string name, longint got, longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask
  // pipe[0] is the youngest producer; rd = 0 marks a slot holding nothing forwardable
  function automatic int youngest(int rs, bit used);
    if (!used || rs == 0) return 0;
    for (int i = 0; i < D - 1; i++) if (pipe[i].rd == rs) return i + 1;
    return 0;
  endfunction
  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < D; i++) pipe.push_back('{rd: 0, ld: 0});
    m_s1 = 0; m_s2 = 0; m_st = 0; m_fw = 0;
  endtask
  task automatic idle();
    bus.id_valid = 0; bus.id_opcode = '0; bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.hold = 0; bus.flush = 0;
  endtask
  task automatic step(bit v, logic [6:0] op, int rd, int rs1, int rs2, bit h, bit f);
    bit u1, u2, wr, kill;
    int s1, s2, stall;
    exp_t e;
    @(negedge clk);
    bus.id_valid = v; bus.id_opcode = op; bus.id_rd = AW'(rd);
    bus.id_rs1 = AW'(rs1); bus.id_rs2 = AW'(rs2); bus.hold = h; bus.flush = f;
    u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2 = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
    wr = !(op inside {OP_STORE, OP_BRANCH});
    s1 = youngest(rs1, u1);
    s2 = youngest(rs2, u2);
    stall = (v && !f && pipe[0].ld && pipe[0].rd != 0 && (s1 == 1 || s2 == 1)) ? 1 : 0;
    kill = stall != 0 || f;
    e.stall = stall;
    if (!h) begin
      void'(pipe.pop_back());
      pipe.push_front('{rd: (v && wr && !kill) ? rd : 0, ld: op == OP_LOAD});
      m_s1 = kill ? 0 : s1;
      m_s2 = kill ? 0 : s2;
`ifdef FWD_STATS_EN
      if (stall != 0 && m_st < 64'hFFFFFFFF) m_st++;
      if ((m_s1 != 0 || m_s2 != 0) && m_fw < 64'hFFFFFFFF) m_fw++;
`endif
    end
    e.s1 = m_s1; e.s2 = m_s2; e.st = m_st; e.fw = m_fw;
    sb.push_back(e);
  endtask
  task automatic reset_checks();
    check("rst_rs1_sel", longint'(bus.rs1_sel), 0);
    check("rst_rs2_sel", longint'(bus.rs2_sel), 0);
    check("rst_stall", longint'(bus.load_use_stall), 0);
    check("rst_stat_stalls", longint'(bus.stat_stalls), 0);
    check("rst_stat_fwds", longint'(bus.stat_fwds), 0);
  endtask
  initial begin : monitor
    exp_t e;
    logic stall_s;
    forever begin
      @(negedge clk);
      #3 stall_s = bus.load_use_stall;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("load_use_stall", longint'(stall_s), e.stall);
        check("rs1_sel", longint'(bus.rs1_sel), e.s1);
        check("rs2_sel", longint'(bus.rs2_sel), e.s2);
        check("stat_stalls", longint'(bus.stat_stalls), e.st);
        check("stat_fwds", longint'(bus.stat_fwds), e.fw);
      end
    end
  end
  initial begin : stim
    logic [6:0] ops [10];
    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_JALR, OP_LOAD};
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_checks();
    reset_n = 1;
    step(1, OP_IMM, 5, 0, 0, 0, 0);
    step(1, OP_RTYPE, 6, 5, 7, 0, 0);
    step(1, OP_IMM, 5, 0, 0, 0, 0);
    step(0, OP_IMM, 0, 0, 0, 0, 0);
    step(1, OP_RTYPE, 8, 0, 5, 0, 0);
    step(1, OP_LOAD, 3, 1, 0, 0, 0);
    step(1, OP_RTYPE, 4, 3, 3, 0, 0);
    step(1, OP_RTYPE, 4, 3, 3, 0, 0);
    step(1, OP_IMM, 9, 0, 0, 0, 0);
    step(1, OP_IMM, 10, 9, 9, 0, 0);
    step(1, OP_LOAD, 3, 1, 0, 0, 0);
    step(1, OP_RTYPE, 4, 3, 1, 0, 1);
    step(1, OP_RTYPE, 4, 3, 1, 0, 0);
    step(1, OP_IMM, 12, 0, 0, 1, 0);
    step(1, OP_IMM, 12, 0, 0, 1, 1);
    step(1, OP_RTYPE, 13, 12, 12, 0, 0);
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(negedge clk);
        reset_n = 0;
        idle();
        model_reset();
        #1 reset_checks();
        @(negedge clk);
        reset_n = 1;
      end
      step($urandom_range(0, 99) < 85, ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 9)],
           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
